// File: rtl/write_burst.sv
// write_burst: SRAM burst writer driving a slow SRAM clock in three phases.
// Ports: clk_in/reset_in, start/abort/mode/a/len/d in, SRAM pins, status out.
module write_burst #(
  parameter int AW    = 9,
  parameter int DW    = 8,
  parameter int LW    = 9,
  parameter int DELAY = 4
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          start_in,
  input  logic          abort_in,
  input  logic [1:0]    mode_in,
  input  logic [AW-1:0] a_in,
  input  logic [LW-1:0] len_in,
  input  logic [DW-1:0] d_in,
  output logic          clk_out,
  output logic          cen_out,
  output logic          wen_out,
  output logic [AW-1:0] a_out,
  output logic [DW-1:0] d_out,
  output logic          writing,
  output logic          done_out,
  output logic [LW-1:0] count_out
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CLK_HI,
    CLK_LO,
    DONE
  } state_t;

  localparam logic [7:0] TMAX = 8'(DELAY - 1);

  state_t        state_q, state_d;
  logic [7:0]    tmr_q, tmr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          abt_q, abt_d;
  logic          clk_q, cen_q, wen_q, wr_q, done_q;
  logic          act_d;
  logic [AW-1:0] addr_nx;

  function automatic logic [DW-1:0] pattern(
    input logic [1:0]    mode,
    input logic [DW-1:0] seed,
    input logic [LW-1:0] idx,
    input logic [AW-1:0] addr
  );
    logic [DW-1:0] r;
    unique case (mode)
      2'd0:    r = seed;
      2'd1:    r = seed + DW'(idx);
      2'd2:    r = DW'(addr);
      default: r = idx[0] ? ~seed : seed;
    endcase
    return r;
  endfunction

  assign addr_nx = addr_q + AW'(1);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    seed_d  = seed_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    data_d  = data_q;
    abt_d   = abt_q;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          len_d  = len_in;
          seed_d = d_in;
          mode_d = mode_in;
          cnt_d  = '0;
          abt_d  = 1'b0;
          if (len_in != '0) begin
            state_d = SETUP;
            tmr_d   = TMAX;
            addr_d  = a_in;
            data_d  = pattern(mode_in, d_in, '0, a_in);
          end else begin
            state_d = DONE;
          end
        end
      end
      SETUP: begin
        if (abort_in) begin
          state_d = DONE;
        end else if (tmr_q == 8'd0) begin
          state_d = CLK_HI;
          tmr_d   = TMAX;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      CLK_HI: begin
        // An abort here is remembered so the high pulse is never cut short.
        if (abort_in) abt_d = 1'b1;
        if (tmr_q == 8'd0) begin
          cnt_d   = cnt_q + LW'(1);
          tmr_d   = TMAX;
          state_d = (abt_q || abort_in) ? DONE : CLK_LO;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      CLK_LO: begin
        if (abort_in) begin
          state_d = DONE;
        end else if (tmr_q == 8'd0) begin
          if (cnt_q == len_q) begin
            state_d = DONE;
          end else begin
            // cnt_q already holds the index of the next word.
            state_d = SETUP;
            tmr_d   = TMAX;
            addr_d  = addr_nx;
            data_d  = pattern(mode_q, seed_q, cnt_q, addr_nx);
          end
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign act_d = (state_d == SETUP) || (state_d == CLK_HI) ||
                 (state_d == CLK_LO);

  // Pin outputs are registered from the next state so they change
  // on the same edge as the state itself.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      mode_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      abt_q   <= 1'b0;
      clk_q   <= 1'b0;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      abt_q   <= abt_d;
      clk_q   <= (state_d == CLK_HI);
      cen_q   <= ~act_d;
      wen_q   <= ~act_d;
      wr_q    <= act_d;
      done_q  <= (state_d == DONE);
    end
  end

  assign clk_out   = clk_q;
  assign cen_out   = cen_q;
  assign wen_out   = wen_q;
  assign a_out     = addr_q;
  assign d_out     = data_q;
  assign writing   = wr_q;
  assign done_out  = done_q;
  assign count_out = cnt_q;

endmodule

// File: tb/tb_write_burst.sv
// tb_write_burst: directed and random bursts against a timing model
// computed from word/phase arithmetic.
module tb_write_burst;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_in = 1'b0;
  logic       abort_in = 1'b0;
  logic [1:0] mode_in = '0;
  logic [8:0] a_in = '0;
  logic [8:0] len_in = '0;
  logic [7:0] d_in = '0;
  logic       clk_out, cen_out, wen_out, writing, done_out;
  logic [8:0] a_out, count_out;
  logic [7:0] d_out;

  int chk_n  = 0;
  int pass_n = 0;

  write_burst #(.AW(9), .DW(8), .LW(9), .DELAY(D)) dut (
    .clk_in(clk), .reset_in(rst), .start_in(start_in),
    .abort_in(abort_in), .mode_in(mode_in), .a_in(a_in),
    .len_in(len_in), .d_in(d_in), .clk_out(clk_out),
    .cen_out(cen_out), .wen_out(wen_out), .a_out(a_out),
    .d_out(d_out), .writing(writing), .done_out(done_out),
    .count_out(count_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    chk_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic int exp_data(int mode, int seed, int a, int w);
    case (mode)
      0: return seed;
      1: return (seed + w) % 256;
      2: return ((a + w) % 512) % 256;
      default: return (w % 2) ? (~seed & 8'hFF) : seed;
    endcase
  endfunction

  task automatic chk_idle(input int cnt);
    chk("idle_wr", writing, 0);
    chk("idle_cen", cen_out, 1);
    chk("idle_wen", wen_out, 1);
    chk("idle_clk", clk_out, 0);
    chk("idle_done", done_out, 0);
    chk("idle_cnt", count_out, cnt);
  endtask

  // ak: cycle (1 = first cycle after start) with abort high, 0 = with start
  // sk: cycle with a stray start pulse; now: start without waiting an edge
  task automatic burst(input int a, input int d, input int len,
                       input int mode, input int ak, input int sk,
                       input bit now);
    int done_k, words, w, o, ph;
    bit wr;
    words  = len;
    done_k = (len == 0) ? 1 : 3 * D * len + 1;
    if (ak >= 1 && ak <= 3 * D * len) begin
      w = (ak - 1) / (3 * D);
      o = (ak - 1) % (3 * D);
      if (o < D) begin
        words = w; done_k = ak + 1;
      end else if (o < 2 * D) begin
        words = w + 1; done_k = 1 + 3 * D * w + 2 * D;
      end else begin
        words = w + 1; done_k = ak + 1;
      end
    end
    if (!now) begin
      @(posedge clk); #1;
    end
    a_in = 9'(a); d_in = 8'(d); len_in = 9'(len); mode_in = 2'(mode);
    start_in = 1'b1;
    abort_in = (ak == 0);
    @(posedge clk); #1;
    start_in = 1'b0; abort_in = 1'b0;
    a_in = 9'($urandom); d_in = 8'($urandom);
    len_in = 9'($urandom); mode_in = 2'($urandom);
    for (int k = 1; k <= done_k + 1; k++) begin
      abort_in = (k == ak);
      start_in = (k == sk) && (k <= done_k);
      @(negedge clk);
      wr = (k < done_k);
      w = (k - 1) / (3 * D);
      o = (k - 1) % (3 * D);
      ph = o / D;
      chk("writing", writing, wr);
      chk("cen", cen_out, !wr);
      chk("wen", wen_out, !wr);
      chk("clk_out", clk_out, wr && ph == 1);
      chk("done", done_out, k == done_k);
      if (wr) begin
        chk("addr", a_out, (a + w) % 512);
        chk("data", d_out, exp_data(mode, d, a, w));
        chk("cnt_run", count_out, w + (ph == 2 ? 1 : 0));
      end else begin
        chk("cnt_end", count_out, words);
      end
      @(posedge clk); #1;
    end
    abort_in = 1'b0; start_in = 1'b0;
  endtask

  initial begin
    int len, ak;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_idle(0);
    chk("rst_a", a_out, 0);
    chk("rst_d", d_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk_idle(0);
    end

    burst(9'h0AB, 8'hCD, 1, 0, -1, -1, 0);
    burst(9'h1FE, 8'h10, 3, 1, -1, -1, 0);
    burst(9'h010, 8'hAA, 4, 3, 3 * D + D + 2, -1, 0);
    burst(9'h1FE, 8'h00, 3, 2, -1, -1, 0);
    burst(9'h123, 8'h5A, 0, 0, -1, -1, 0);
    burst(9'h040, 8'h33, 2, 1, -1, 7, 0);
    burst(9'h050, 8'h44, 2, 0, 0, -1, 0);
    burst(9'h060, 8'h77, 3, 3, 3, -1, 0);
    burst(9'h070, 8'h88, 3, 1, 3 * D + 2 * D + 1, -1, 0);

    @(posedge clk); #1;
    a_in = 9'h100; d_in = 8'h20; len_in = 9'd4; mode_in = 2'd1;
    start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (3 * D + D + 1) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_clk", clk_out, 1);
    chk("pre_rst_cnt", count_out, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_clk", clk_out, 0);
    chk("rst_cen", cen_out, 1);
    chk("rst_wen", wen_out, 1);
    chk("rst_cnt", count_out, 0);
    chk("rst_wr", writing, 0);
    chk("rst_a2", a_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    burst(9'h0F0, 8'h01, 2, 1, -1, -1, 1);

    for (int t = 0; t < 15; t++) begin
      len = $urandom_range(0, 5);
      ak = ($urandom_range(0, 2) == 0) ? -1 :
           $urandom_range(0, 3 * D * len + 2);
      burst($urandom_range(0, 511), $urandom_range(0, 255), len,
            $urandom_range(0, 3), ak,
            ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, 12), 0);
    end
    repeat (3) begin
      @(negedge clk);
      chk("quiet_wr", writing, 0);
      chk("quiet_cen", cen_out, 1);
    end

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule

// File: doc/write_burst.md
WRITE_BURST -- requirements
Module: write_burst

Interface
REQ-001 Parameter AW, default 9, SRAM address width.
REQ-002 Parameter DW, default 8, SRAM data width.
REQ-003 Parameter LW, default 9, burst-length field width.
REQ-004 Parameter DELAY, default 4, cycles per SRAM-clock phase (setup, high, low); legal range 1..255.
REQ-005 clk_in  input  1  system clock (100 MHz).
REQ-006 reset_in  input  1  reset, asynchronous, active-high.
REQ-007 start_in  input  1  single-cycle start pulse.
REQ-008 abort_in  input  1  request early burst termination.
REQ-009 mode_in  input  2  data-pattern select.
REQ-010 a_in  input  AW  burst start address.
REQ-011 len_in  input  LW  number of words to write.
REQ-012 d_in  input  DW  seed data word.
REQ-013 clk_out  output  1  SRAM clock.
REQ-014 cen_out  output  1  SRAM chip enable, active-low.
REQ-015 wen_out  output  1  SRAM write enable, active-low.
REQ-016 a_out  output  AW  SRAM address.
REQ-017 d_out  output  DW  SRAM write data.
REQ-018 writing  output  1  burst in progress.
REQ-019 done_out  output  1  one-cycle end-of-burst pulse.
REQ-020 count_out  output  LW  words completed in current/last burst.

Function
REQ-021 States SHALL be IDLE, SETUP, CLK_HI, CLK_LO, DONE; all outputs registered.
REQ-022 IDLE: clk_out=0, cen_out=1, wen_out=1, writing=0, done_out=0; a_out/d_out hold last values.
REQ-023 start_in=1 in IDLE SHALL latch a_in, len_in, d_in, mode_in, clear count_out, and go to SETUP (len_in≠0) or DONE (len_in=0); start_in outside IDLE ignored.
REQ-024 SETUP: cen_out=0, wen_out=0, clk_out=0, a_out/d_out valid for word i, held DELAY cycles, then CLK_HI.
REQ-025 CLK_HI: clk_out=1 for exactly DELAY cycles, a_out/d_out/cen_out/wen_out stable; on exit count_out increments.
REQ-026 CLK_LO: clk_out=0, DELAY cycles, controls still asserted; exit to DONE if count_out=len, else SETUP with word i+1.
REQ-027 writing=1 in SETUP, CLK_HI, CLK_LO only; each word occupies 3*DELAY cycles.
REQ-028 DONE: one cycle, done_out=1, cen_out=1, wen_out=1, clk_out=0, then IDLE.
REQ-029 Address for word i = (a_start + i) mod 2^AW (wraps 2^AW-1 -> 0).
REQ-030 Data: mode 0 = d_seed; mode 1 = (d_seed + i) mod 2^DW; mode 2 = a_out low DW bits, zero-extended if AW<DW; mode 3 = d_seed on even i, ~d_seed on odd i.
REQ-031 abort_in=1 in SETUP or CLK_LO SHALL go to DONE next cycle; in CLK_HI the high phase SHALL complete its full DELAY cycles (count increments) before DONE; clk_out never truncated.
REQ-032 abort_in in IDLE/DONE ignored; abort and start same cycle in IDLE: start wins.
REQ-033 count_out holds final value until next accepted start.

Reset
REQ-034 reset_in=1 SHALL asynchronously force IDLE, clk_out=0, cen_out=1, wen_out=1, writing=0, done_out=0, a_out=0, d_out=0, count_out=0, including mid-burst.
REQ-035 After release, first accepted start_in SHALL be at first rising edge with reset_in=0.

Verification (AW=9, DW=8, DELAY=4)
REQ-036 Reset held 10 cycles then released -> outputs per REQ-034; no activity without start.
REQ-037 start, a=0x0AB, d=0xCD, len=1, mode 0 -> cen/wen low 12 cycles, clk_out high cycles 5-8 after start, a_out=0x0AB, d_out=0xCD, done_out pulse cycle 13, count_out=1.
REQ-038 a=0x1FE, d=0x10, len=3, mode 1 -> addresses 0x1FE,0x1FF,0x000, data 0x10,0x11,0x12, three clk_out pulses, writing 36 cycles, count_out=3.
REQ-039 len=4, mode 3, d=0xAA, abort asserted 2nd cycle of word-2 CLK_HI -> high phase completes 4 cycles, data 0xAA,0x55, count_out=2, done_out next cycle after high phase.
REQ-040 len=0 -> done_out on next cycle, cen_out never low; start during burst -> ignored, burst unchanged.
REQ-041 reset_in asserted during CLK_HI of word 2 -> same-cycle clk_out=0, cen_out=1, count_out=0, IDLE.
